// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, request field offsets, FSM encoding and block-address helper for mem_bus_arbiter.
package mem_bus_pkg;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 8;
    localparam int BLOCK_W      = 16;
    localparam int REQ_WE_BIT   = 24;
    localparam int REQ_DATA_LSB = 16;
    localparam int REQ_ADDR_LSB = 0;
    localparam int REQ_W        = 1 + DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Two bytes per block: clearing bit 0 never wraps, so 65535 maps to 65534.
    function automatic logic [ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] addr);
        return addr & ~{{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: cache-side, memory-side and status signals of the two-port memory-bus arbiter.
interface mem_bus_arbiter_if;
    import mem_bus_pkg::*;

    logic [REQ_W-1:0]   cpu_request_0;
    logic [REQ_W-1:0]   cpu_request_1;
    logic               cpu_request_ready_0;
    logic               cpu_request_ready_1;
    logic [BLOCK_W-1:0] response_0;
    logic [BLOCK_W-1:0] response_1;
    logic               response_ready_0;
    logic               response_ready_1;
    logic [REQ_W-1:0]   memory_request;
    logic               memory_request_ready;
    logic [BLOCK_W-1:0] memory_response;
    logic               memory_response_ready;
    logic [ADDR_W-1:0]  invalidate_address_0;
    logic [ADDR_W-1:0]  invalidate_address_1;
    logic               invalidate_valid_0;
    logic               invalidate_valid_1;
    logic               grant;
    logic               busy;

    modport master (
        input  cpu_request_0, cpu_request_1, cpu_request_ready_0, cpu_request_ready_1,
        input  memory_response, memory_response_ready,
        output response_0, response_1, response_ready_0, response_ready_1,
        output memory_request, memory_request_ready,
        output invalidate_address_0, invalidate_address_1, invalidate_valid_0, invalidate_valid_1,
        output grant, busy
    );

    modport slave (
        output cpu_request_0, cpu_request_1, cpu_request_ready_0, cpu_request_ready_1,
        output memory_response, memory_response_ready,
        input  response_0, response_1, response_ready_0, response_ready_1,
        input  memory_request, memory_request_ready,
        input  invalidate_address_0, invalidate_address_1, invalidate_valid_0, invalidate_valid_1,
        input  grant, busy
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin picker; a tie goes to the port that did not win last.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_idx,
    output logic       o_valid,
    output logic       o_last
);
    logic r_last;

    assign o_valid = |i_req;
    assign o_idx   = &i_req ? ~r_last : i_req[1];
    assign o_last  = r_last;

    // Resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= 1'b1;
        else if (i_en && o_valid)
            r_last <= o_idx;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-cache memory arbiter with IDLE/ISSUE/RESPOND sequencing.
// Define MEM_BUS_INVALIDATE_EN to broadcast a block invalidate to the other cache on every write.
module mem_bus_arbiter
    import mem_bus_pkg::*;
(
    input logic               clock,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    state_t             r_state;
    logic [REQ_W-1:0]   r_mem_req;
    logic [BLOCK_W-1:0] r_resp_0;
    logic [BLOCK_W-1:0] r_resp_1;
    logic               r_resp_rdy_0;
    logic               r_resp_rdy_1;
    logic               r_mrr_prev;
    logic               w_idle;
    logic               w_idx;
    logic               w_valid;
    logic               w_last;
    logic               w_accept;
    logic [REQ_W-1:0]   w_sel_req;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_sel_req = w_idx ? bus.cpu_request_1 : bus.cpu_request_0;
    // Only a fresh rising level is consumed, so a level left over from the last transaction is ignored.
    assign w_accept  = (r_state == ST_ISSUE) && bus.memory_response_ready && !r_mrr_prev;

    rr_arbiter_2 u_rr (
        .clk     (clock),
        .rst     (reset),
        .i_req   ({bus.cpu_request_ready_1, bus.cpu_request_ready_0}),
        .i_en    (w_idle),
        .o_idx   (w_idx),
        .o_valid (w_valid),
        .o_last  (w_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= '0;
            r_resp_0     <= '0;
            r_resp_1     <= '0;
            r_resp_rdy_0 <= 1'b0;
            r_resp_rdy_1 <= 1'b0;
            r_mrr_prev   <= 1'b0;
        end else begin
            r_mrr_prev   <= bus.memory_response_ready;
            r_resp_rdy_0 <= 1'b0;
            r_resp_rdy_1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_mem_req <= w_sel_req;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_resp_1     <= bus.memory_response;
                            r_resp_rdy_1 <= 1'b1;
                        end else begin
                            r_resp_0     <= bus.memory_response;
                            r_resp_rdy_0 <= 1'b1;
                        end
                        r_state <= ST_RESPOND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.response_0           = r_resp_0;
    assign bus.response_1           = r_resp_1;
    assign bus.response_ready_0     = r_resp_rdy_0;
    assign bus.response_ready_1     = r_resp_rdy_1;
    assign bus.memory_request       = r_mem_req;
    assign bus.memory_request_ready = (r_state == ST_ISSUE);
    assign bus.grant                = w_last;
    assign bus.busy                 = !w_idle;

`ifdef MEM_BUS_INVALIDATE_EN
    logic [ADDR_W-1:0] r_inv_addr_0;
    logic [ADDR_W-1:0] r_inv_addr_1;
    logic              r_inv_v_0;
    logic              r_inv_v_1;
    logic              w_inv;

    // Raised on the accepting edge so the strobe lines up with the writer's response pulse.
    assign w_inv = w_accept && r_mem_req[REQ_WE_BIT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inv_addr_0 <= '0;
            r_inv_addr_1 <= '0;
            r_inv_v_0    <= 1'b0;
            r_inv_v_1    <= 1'b0;
        end else begin
            r_inv_v_0 <= w_inv && w_last;
            r_inv_v_1 <= w_inv && !w_last;
            if (w_inv && w_last)
                r_inv_addr_0 <= block_addr(r_mem_req[REQ_ADDR_LSB +: ADDR_W]);
            if (w_inv && !w_last)
                r_inv_addr_1 <= block_addr(r_mem_req[REQ_ADDR_LSB +: ADDR_W]);
        end
    end

    assign bus.invalidate_address_0 = r_inv_addr_0;
    assign bus.invalidate_address_1 = r_inv_addr_1;
    assign bus.invalidate_valid_0   = r_inv_v_0;
    assign bus.invalidate_valid_1   = r_inv_v_1;
`else
    assign bus.invalidate_address_0 = '0;
    assign bus.invalidate_address_1 = '0;
    assign bus.invalidate_valid_0   = 1'b0;
    assign bus.invalidate_valid_1   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table, corner-case sequences and random traffic against a queue-based model.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

`ifdef MEM_BUS_INVALIDATE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    typedef logic [24:0] req_t;
    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  data;
        logic [15:0] addr;
        logic [15:0] mdata;
        int          dly;
        logic [15:0] exp_resp;
        bit          exp_inv;
        logic [15:0] exp_ia;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    mem_bus_arbiter_if bus();

    mem_bus_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    bit          auto_mem = 1'b1;
    int          mem_delay = 0;
    int          wait_cnt = 0;
    bit          ovr_en = 1'b0;
    logic [15:0] ovr_data = '0;
    req_t        pq0[$];
    req_t        pq1[$];
    req_t        cur[2];
    bit          active[2];
    bit          got[2];
    int          age[2];
    int          skips[2];
    int          pulses[2];
    int          invs[2];
    int          mis_coinc = 0;
    bit          chk_en = 1'b0;
    req_t        seen[$];
    logic        prev_mrq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Memory contents as seen by the bench: any fixed function of the whole request.
    function automatic logic [15:0] mem_fn(input req_t r);
        return (r[15:0] * 16'd3) ^ {r[23:16], 7'd0, r[24]};
    endfunction

    function automatic req_t rnd_req();
        return {1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom)};
    endfunction

    function automatic logic [15:0] resp(input int p);
        return p != 0 ? bus.response_1 : bus.response_0;
    endfunction
    function automatic logic rrdy(input int p);
        return p != 0 ? bus.response_ready_1 : bus.response_ready_0;
    endfunction
    function automatic logic ivv(input int p);
        return p != 0 ? bus.invalidate_valid_1 : bus.invalidate_valid_0;
    endfunction
    function automatic logic [15:0] iva(input int p);
        return p != 0 ? bus.invalidate_address_1 : bus.invalidate_address_0;
    endfunction

    task automatic present(input int p, input req_t r, input logic rdy);
        if (p != 0) begin
            bus.cpu_request_1 = r;
            bus.cpu_request_ready_1 = rdy;
        end else begin
            bus.cpu_request_0 = r;
            bus.cpu_request_ready_0 = rdy;
        end
    endtask

    task automatic clr();
        pulses[0] = 0; pulses[1] = 0;
        invs[0] = 0;   invs[1] = 0;
        mis_coinc = 0;
        seen.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((pq0.size() != 0 || pq1.size() != 0 || active[0] || active[1]) && n < 300) begin
            @(posedge clock);
            n++;
        end
        if (n >= 300) begin
            fail_now(name);
            pq0.delete(); pq1.delete();
            active[0] = 0; active[1] = 0;
            present(0, '0, 0); present(1, '0, 0);
        end
        repeat (2) @(posedge clock);
        #2;
    endtask

    // Memory responder: one-cycle response pulse after mem_delay cycles of memory_request_ready.
    initial begin
        bus.memory_response = '0;
        bus.memory_response_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (auto_mem) begin
                if (bus.memory_response_ready)
                    bus.memory_response_ready = 1'b0;
                else if (bus.memory_request_ready) begin
                    if (wait_cnt >= mem_delay) begin
                        bus.memory_response = ovr_en ? ovr_data : mem_fn(bus.memory_request);
                        bus.memory_response_ready = 1'b1;
                        wait_cnt = 0;
                    end else
                        wait_cnt++;
                end else
                    wait_cnt = 0;
            end
        end
    end

    // Requesters: hold a request until its response pulse, then drop it or present the next one.
    initial begin
        present(0, '0, 0);
        present(1, '0, 0);
        forever begin
            @(posedge clock);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (got[p]) begin
                    active[p] = 0;
                    got[p] = 0;
                    present(p, '0, 0);
                end
                if (!active[p] && (p == 0 ? pq0.size() != 0 : pq1.size() != 0)) begin
                    cur[p] = (p == 0) ? pq0.pop_front() : pq1.pop_front();
                    present(p, cur[p], 1);
                    active[p] = 1;
                    age[p] = 0;
                    skips[p] = 0;
                end
            end
        end
    end

    // Monitor and reference checks, sampled mid-cycle.
    always @(negedge clock) begin
        int o;
        if (bus.memory_request_ready && !prev_mrq)
            seen.push_back(bus.memory_request);
        prev_mrq = bus.memory_request_ready;
        for (int p = 0; p < 2; p++) begin
            o = 1 - p;
            if (active[p] && !got[p]) begin
                age[p]++;
                if (age[p] == 80) fail_now("req_timeout");
            end
            if (rrdy(p)) begin
                pulses[p]++;
                if (active[p] && !got[p]) begin
                    got[p] = 1;
                    if (chk_en) begin
                        check("rand_resp", resp(p), mem_fn(cur[p]));
                        check("rand_grant", bus.grant, p);
                        check("rand_inv_v", ivv(o), INV_EN && cur[p][24]);
                        check("rand_own_inv", ivv(p), 0);
                        if (INV_EN && cur[p][24])
                            check("rand_inv_a", iva(o), cur[p][15:0] & 16'hFFFE);
                        if (active[o] && !got[o]) skips[o]++;
                        skips[p] = 0;
                        check("rand_fair", skips[o] <= 1, 1);
                    end
                end else if (chk_en)
                    fail_now("spurious_resp");
            end
            if (ivv(p)) begin
                invs[p]++;
                if (!rrdy(o)) mis_coinc++;
            end
        end
    end

    initial begin
        vec_t        tbl[6];
        logic [15:0] hold[2];
        logic [15:0] ia[2];
        req_t        r;
        int          p;
        int          o;
        int          n;
        bit          ei;

        tbl[0] = '{0, 0, 8'd0,   16'd12,    16'hBEEF, 1, 16'hBEEF, 0, 16'd0};
        tbl[1] = '{1, 1, 8'd55,  16'd13,    16'h1234, 0, 16'h1234, 1, 16'd12};
        tbl[2] = '{0, 1, 8'hAA,  16'd65535, 16'hCAFE, 2, 16'hCAFE, 1, 16'd65534};
        tbl[3] = '{1, 0, 8'h00,  16'd7,     16'h0F0F, 3, 16'h0F0F, 0, 16'd0};
        tbl[4] = '{0, 1, 8'h01,  16'd0,     16'h0001, 0, 16'h0001, 1, 16'd0};
        tbl[5] = '{1, 1, 8'h7E,  16'd1,     16'hFFFF, 1, 16'hFFFF, 1, 16'd0};
        active[0] = 0; active[1] = 0; got[0] = 0; got[1] = 0;
        clr();

        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant, 1);
        check("rst_mrq", bus.memory_request_ready, 0);
        check("rst_mreq", bus.memory_request, 0);
        check("rst_resp0", bus.response_0, 0);
        check("rst_resp1", bus.response_1, 0);
        check("rst_rrdy", {bus.response_ready_1, bus.response_ready_0}, 0);
        check("rst_inv_v", {bus.invalidate_valid_1, bus.invalidate_valid_0}, 0);
        check("rst_inv_a", {bus.invalidate_address_1, bus.invalidate_address_0}, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;

        // First tie after reset goes to port 0, then port 1; the next tie goes to port 0 again.
        clr();
        pq0.push_back({1'b0, 8'd0, 16'd4});
        pq1.push_back({1'b0, 8'd0, 16'd8});
        wait_idle("tie1");
        pq0.push_back({1'b0, 8'd0, 16'd20});
        pq1.push_back({1'b0, 8'd0, 16'd24});
        wait_idle("tie2");
        check("tie_count", seen.size(), 4);
        check("tie_first", seen.size() > 0 ? seen[0][15:0] : 16'hFFFF, 4);
        check("tie_second", seen.size() > 1 ? seen[1][15:0] : 16'hFFFF, 8);
        check("tie_third", seen.size() > 2 ? seen[2][15:0] : 16'hFFFF, 20);
        check("tie_pulses0", pulses[0], 2);
        check("tie_pulses1", pulses[1], 2);
        hold[0] = mem_fn({1'b0, 8'd0, 16'd20});
        hold[1] = mem_fn({1'b0, 8'd0, 16'd24});
        check("tie_resp0", bus.response_0, hold[0]);
        check("tie_resp1", bus.response_1, hold[1]);
        ia[0] = '0; ia[1] = '0;

        ovr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clr();
            ovr_data = tbl[i].mdata;
            mem_delay = tbl[i].dly;
            r = {tbl[i].we, tbl[i].data, tbl[i].addr};
            if (tbl[i].port) pq1.push_back(r); else pq0.push_back(r);
            wait_idle("tbl_wait");
            p = int'(tbl[i].port);
            o = 1 - p;
            ei = INV_EN && tbl[i].exp_inv;
            if (ei) ia[o] = tbl[i].exp_ia;
            hold[p] = tbl[i].exp_resp;
            check("tbl_resp", resp(p), tbl[i].exp_resp);
            check("tbl_pulse", pulses[p], 1);
            check("tbl_other_pulse", pulses[o], 0);
            check("tbl_memreq", seen.size() == 1 ? seen[0] : '1, r);
            check("tbl_inv_cnt", invs[o], ei);
            check("tbl_own_inv", invs[p], 0);
            check("tbl_inv_addr0", bus.invalidate_address_0, ia[0]);
            check("tbl_inv_addr1", bus.invalidate_address_1, ia[1]);
            check("tbl_coinc", mis_coinc, 0);
            check("tbl_hold", resp(o), hold[o]);
        end
        ovr_en = 1'b0;
        mem_delay = 0;

        // A response level held over from the previous transaction must not be consumed.
        clr();
        auto_mem = 1'b0;
        pq0.push_back({1'b0, 8'd0, 16'd40});
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.memory_request_ready && n < 30);
        if (n >= 30) fail_now("hold_wait_issue0");
        @(posedge clock);
        #1;
        bus.memory_response = 16'h1111;
        bus.memory_response_ready = 1'b1;
        pq1.push_back({1'b0, 8'd0, 16'd44});
        n = 0;
        while (!(pulses[0] == 1 && bus.memory_request_ready) && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (n >= 30) fail_now("hold_wait_issue1");
        repeat (3) begin
            @(negedge clock);
            check("hold_mrq", bus.memory_request_ready, 1);
            check("hold_no_resp", bus.response_ready_1, 0);
        end
        check("hold_busy", bus.busy, 1);
        check("hold_grant", bus.grant, 1);
        @(posedge clock);
        #1 begin bus.memory_response_ready = 1'b0; bus.memory_response = 16'h2222; end
        @(posedge clock);
        #1 begin bus.memory_response = 16'h3333; bus.memory_response_ready = 1'b1; end
        @(posedge clock);
        #1 bus.memory_response_ready = 1'b0;
        wait_idle("hold_done");
        check("hold_resp1", bus.response_1, 16'h3333);
        check("hold_resp0", bus.response_0, 16'h1111);
        check("hold_pulse1", pulses[1], 1);

        // Reset in ISSUE drops the transaction with no response or invalidate.
        clr();
        pq0.push_back({1'b1, 8'h05, 16'd100});
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.memory_request_ready && n < 30);
        if (n >= 30) fail_now("rst_wait_issue");
        check("pre_rst_grant", bus.grant, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_mrq", bus.memory_request_ready, 0);
        check("mid_rst_grant", bus.grant, 1);
        check("mid_rst_mreq", bus.memory_request, 0);
        present(0, '0, 0);
        active[0] = 0;
        bus.memory_response = 16'h9999;
        bus.memory_response_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 bus.memory_response_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_pulses", pulses[0] + pulses[1], 0);
        check("post_rst_invs", invs[0] + invs[1], 0);
        check("post_rst_busy", bus.busy, 0);
        auto_mem = 1'b1;

        // Random traffic checked against the queue model in the monitor.
        chk_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clock);
            #2;
            mem_delay = $urandom_range(0, 3);
            if (pq0.size() == 0 && !active[0] && $urandom_range(0, 2) == 0) pq0.push_back(rnd_req());
            if (pq1.size() == 0 && !active[1] && $urandom_range(0, 2) == 0) pq1.push_back(rnd_req());
        end
        wait_idle("rand_drain");
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
